// File: rtl/ahb_fir_pkg.sv
// -----------------------------------------------------------------------------
// ahb_fir_pkg
// Shared constants and types for the AHB-Lite FIR initiator:
//   - ahb_lite_fir_filter register map (byte addresses)
//   - AHB-Lite htrans encodings used by this initiator (IDLE / NONSEQ only)
//   - status register bit positions
//   - top-level FSM state enumeration
// -----------------------------------------------------------------------------
package ahb_fir_pkg;

    localparam int FIR_DATA_W = 16;
    localparam int ADDR_W     = 4;
    localparam int NUM_COEF   = 4;

    // Register map of ahb_lite_fir_filter
    localparam logic [ADDR_W-1:0] ADDR_STATUS   = 4'd0;
    localparam logic [ADDR_W-1:0] ADDR_RESULT   = 4'd2;
    localparam logic [ADDR_W-1:0] ADDR_SAMPLE   = 4'd4;
    localparam logic [ADDR_W-1:0] ADDR_COEF0    = 4'd6;
    localparam logic [ADDR_W-1:0] ADDR_COEF_SET = 4'd14;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam int STATUS_BUSY_BIT = 0;
    localparam int STATUS_ERR_BIT  = 8;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_COEF_WR,
        ST_COEF_SET,
        ST_COEF_POLL,
        ST_READY,
        ST_SAMPLE_WR,
        ST_STAT_POLL,
        ST_RESULT_RD,
        ST_ERR
    } state_t;

    // Coefficient k lives at COEF0 + 2*k (16-bit registers, byte addressed)
    function automatic logic [ADDR_W-1:0] coef_addr(input logic [1:0] idx);
        return ADDR_COEF0 + {1'b0, idx, 1'b0};
    endfunction

endpackage

// File: rtl/ahb_lite_master_pipe.sv
// -----------------------------------------------------------------------------
// ahb_lite_master_pipe
// AHB-Lite bus pipeline for a zero-wait-state slave. A request presented in
// cycle N becomes the address phase in cycle N+1 and the data phase in N+2.
// Write data is held one extra cycle so hwdata lines up with the data phase.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_write      request a NONSEQ transfer next cycle
//   req_addr/req_wdata       address and (for writes) data of that request
//   hsel/htrans/haddr/hwrite address-phase outputs (registered)
//   hwdata                   data-phase write data (registered)
//   hrdata/hresp             slave data-phase response
//   addr_rd                  a read is in its address phase this cycle
//   rdata_valid/rdata        read data-phase strobe and data, this cycle
//   resp_err                 hresp seen in a data phase, this cycle
// -----------------------------------------------------------------------------
module ahb_lite_master_pipe
    import ahb_fir_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              hsel,
    output logic [1:0]        htrans,
    output logic [ADDR_W-1:0] haddr,
    output logic              hwrite,
    output logic [DATA_W-1:0] hwdata,
    input  logic [DATA_W-1:0] hrdata,
    input  logic              hresp,
    output logic              addr_rd,
    output logic              rdata_valid,
    output logic [DATA_W-1:0] rdata,
    output logic              resp_err
);

    logic              hsel_reg;
    logic [1:0]        htrans_reg;
    logic [ADDR_W-1:0] haddr_reg;
    logic              hwrite_reg;
    logic [DATA_W-1:0] wdata_addr_reg;   // write data waiting for its data phase
    logic [DATA_W-1:0] hwdata_reg;
    logic              dphase_valid_reg;
    logic              dphase_write_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            hsel_reg         <= 1'b0;
            htrans_reg       <= HTRANS_IDLE;
            haddr_reg        <= '0;
            hwrite_reg       <= 1'b0;
            wdata_addr_reg   <= '0;
            hwdata_reg       <= '0;
            dphase_valid_reg <= 1'b0;
            dphase_write_reg <= 1'b0;
        end else begin
            hsel_reg         <= req_valid;
            htrans_reg       <= req_valid ? HTRANS_NONSEQ : HTRANS_IDLE;
            haddr_reg        <= req_valid ? req_addr : '0;
            hwrite_reg       <= req_valid && req_write;
            wdata_addr_reg   <= (req_valid && req_write) ? req_wdata : '0;
            // Data phase of whatever is in the address phase now
            hwdata_reg       <= (htrans_reg == HTRANS_NONSEQ && hwrite_reg) ? wdata_addr_reg : '0;
            dphase_valid_reg <= (htrans_reg == HTRANS_NONSEQ);
            dphase_write_reg <= hwrite_reg;
        end
    end

    assign hsel        = hsel_reg;
    assign htrans      = htrans_reg;
    assign haddr       = haddr_reg;
    assign hwrite      = hwrite_reg;
    assign hwdata      = hwdata_reg;
    assign addr_rd     = (htrans_reg == HTRANS_NONSEQ) && !hwrite_reg;
    assign rdata_valid = dphase_valid_reg && !dphase_write_reg;
    assign rdata       = hrdata;
    assign resp_err    = dphase_valid_reg && hresp;

endmodule

// File: rtl/ahb_lite_fir_master.sv
// -----------------------------------------------------------------------------
// ahb_lite_fir_master
// AHB-Lite initiator for ahb_lite_fir_filter. Loads four coefficients,
// commits the set and waits for it to be taken, then for each host sample:
// writes the sample, polls status until idle, reads the result and pulses it
// out to the host.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   coef_load       start coefficient load (taken in IDLE/READY only)
//   coef_in         {F3,F2,F1,F0}, sampled on the accepted coef_load cycle
//   sample_valid    host sample available
//   sample_data     host sample value
//   sample_ready    high in READY; sample transfers on valid && ready
//   result_valid    one-cycle pulse qualifying result_data
//   result_data     result register read from the filter
//   busy            high in every state except IDLE, READY, ERR
//   err             sticky error (bus error, status error bit, poll timeout)
//   hsel..hwdata    AHB-Lite initiator outputs
//   hrdata, hresp   AHB-Lite slave response
//
// Build option: define POLL_TIMEOUT_EN to bound COEF_POLL / STAT_POLL to
// POLL_LIMIT busy responses; otherwise polling is unbounded.
// -----------------------------------------------------------------------------
module ahb_lite_fir_master
    import ahb_fir_pkg::*;
#(
    parameter int POLL_LIMIT = 64,
    parameter int DATA_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  coef_load,
    input  logic [4*DATA_W-1:0]   coef_in,
    input  logic                  sample_valid,
    input  logic [DATA_W-1:0]     sample_data,
    output logic                  sample_ready,
    output logic                  result_valid,
    output logic [DATA_W-1:0]     result_data,
    output logic                  busy,
    output logic                  err,
    output logic                  hsel,
    output logic [1:0]            htrans,
    output logic [ADDR_W-1:0]     haddr,
    output logic                  hsize,
    output logic                  hwrite,
    output logic [DATA_W-1:0]     hwdata,
    input  logic [DATA_W-1:0]     hrdata,
    input  logic                  hresp
);

    // Elaboration-time parameter sanity
    if (DATA_W != FIR_DATA_W) begin : g_bad_width
        $error("ahb_lite_fir_master: DATA_W must be 16");
    end
    if (POLL_LIMIT < 1 || POLL_LIMIT > 128) begin : g_bad_limit
        $error("ahb_lite_fir_master: POLL_LIMIT must be 1..128");
    end

    state_t            state_reg, state_next;
    logic [1:0]        coef_idx_reg, coef_idx_next;
    logic              err_reg, err_next;
    logic              result_valid_reg, result_valid_next;
    logic [DATA_W-1:0] result_data_reg, result_data_next;
    logic              load_coef;

    logic              req_valid;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              addr_rd;
    logic              rdata_valid;
    logic [DATA_W-1:0] rdata;
    logic              resp_err;

    logic              poll_busy;
    logic              poll_expired;

    // ------------------------------------------------------------------
    // Coefficient storage, one register per tap
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] coef_word [NUM_COEF];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_COEF; gi++) begin : g_coef
            logic [DATA_W-1:0] coef_reg;
            always_ff @(posedge clk) begin
                if (rst) begin
                    coef_reg <= '0;
                end else if (load_coef) begin
                    coef_reg <= coef_in[gi*DATA_W +: DATA_W];
                end
            end
            assign coef_word[gi] = coef_reg;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Bus pipeline
    // ------------------------------------------------------------------
    ahb_lite_master_pipe #(
        .DATA_W (DATA_W)
    ) u_pipe (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .hsel        (hsel),
        .htrans      (htrans),
        .haddr       (haddr),
        .hwrite      (hwrite),
        .hwdata      (hwdata),
        .hrdata      (hrdata),
        .hresp       (hresp),
        .addr_rd     (addr_rd),
        .rdata_valid (rdata_valid),
        .rdata       (rdata),
        .resp_err    (resp_err)
    );

    assign poll_busy = rdata_valid && rdata[STATUS_BUSY_BIT];

    // ------------------------------------------------------------------
    // Optional poll timeout. The counter clears whenever the state
    // changes, so each polling state starts from zero.
    // ------------------------------------------------------------------
`ifdef POLL_TIMEOUT_EN
    localparam logic [6:0] POLL_LAST = 7'(POLL_LIMIT - 1);
    logic [6:0] poll_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst || state_next != state_reg) begin
            poll_cnt_reg <= '0;
        end else if (poll_busy) begin
            poll_cnt_reg <= poll_cnt_reg + 7'd1;
        end
    end

    assign poll_expired = (poll_cnt_reg == POLL_LAST);
`else
    assign poll_expired = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= ST_IDLE;
            coef_idx_reg     <= '0;
            err_reg          <= 1'b0;
            result_valid_reg <= 1'b0;
            result_data_reg  <= '0;
        end else begin
            state_reg        <= state_next;
            coef_idx_reg     <= coef_idx_next;
            err_reg          <= err_next;
            result_valid_reg <= result_valid_next;
            result_data_reg  <= result_data_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state. Requests issued here appear on the bus as address
    // phases in the following cycle.
    // ------------------------------------------------------------------
    always_comb begin
        state_next        = state_reg;
        coef_idx_next     = coef_idx_reg;
        err_next          = err_reg;
        result_valid_next = 1'b0;
        result_data_next  = result_data_reg;
        load_coef         = 1'b0;
        req_valid         = 1'b0;
        req_write         = 1'b0;
        req_addr          = '0;
        req_wdata         = '0;

        // A bus error in any data phase stops all further transfers
        if (resp_err && state_reg != ST_ERR) begin
            state_next = ST_ERR;
            err_next   = 1'b1;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (coef_load) begin
                        load_coef     = 1'b1;
                        req_valid     = 1'b1;
                        req_write     = 1'b1;
                        req_addr      = ADDR_COEF0;
                        req_wdata     = coef_in[DATA_W-1:0];  // F0 straight from the port
                        coef_idx_next = 2'd1;
                        state_next    = ST_COEF_WR;
                    end
                end

                ST_COEF_WR: begin
                    req_valid     = 1'b1;
                    req_write     = 1'b1;
                    req_addr      = coef_addr(coef_idx_reg);
                    req_wdata     = coef_word[coef_idx_reg];
                    coef_idx_next = coef_idx_reg + 2'd1;
                    if (coef_idx_reg == 2'd3) begin
                        state_next = ST_COEF_SET;
                    end
                end

                ST_COEF_SET: begin
                    req_valid  = 1'b1;
                    req_write  = 1'b1;
                    req_addr   = ADDR_COEF_SET;
                    req_wdata  = 16'h0001;
                    state_next = ST_COEF_POLL;
                end

                ST_COEF_POLL: begin
                    // One read outstanding at a time: issue when the bus
                    // holds no read, or when the last read came back busy.
                    if (rdata_valid && !rdata[STATUS_BUSY_BIT]) begin
                        state_next = ST_READY;
                    end else if (poll_busy && poll_expired) begin
                        state_next = ST_ERR;
                        err_next   = 1'b1;
                    end else if (poll_busy || !addr_rd) begin
                        req_valid = 1'b1;
                        req_addr  = ADDR_COEF_SET;
                    end
                end

                ST_READY: begin
                    // A sample handshake wins over a simultaneous coef_load
                    if (sample_valid) begin
                        req_valid  = 1'b1;
                        req_write  = 1'b1;
                        req_addr   = ADDR_SAMPLE;
                        req_wdata  = sample_data;
                        state_next = ST_SAMPLE_WR;
                    end else if (coef_load) begin
                        load_coef     = 1'b1;
                        req_valid     = 1'b1;
                        req_write     = 1'b1;
                        req_addr      = ADDR_COEF0;
                        req_wdata     = coef_in[DATA_W-1:0];
                        coef_idx_next = 2'd1;
                        state_next    = ST_COEF_WR;
                    end
                end

                ST_SAMPLE_WR: begin
                    // First status read overlaps the sample write's data phase
                    req_valid  = 1'b1;
                    req_addr   = ADDR_STATUS;
                    state_next = ST_STAT_POLL;
                end

                ST_STAT_POLL: begin
                    if (rdata_valid && rdata[STATUS_ERR_BIT]) begin
                        state_next = ST_ERR;
                        err_next   = 1'b1;
                    end else if (rdata_valid && !rdata[STATUS_BUSY_BIT]) begin
                        req_valid  = 1'b1;
                        req_addr   = ADDR_RESULT;
                        state_next = ST_RESULT_RD;
                    end else if (poll_busy && poll_expired) begin
                        state_next = ST_ERR;
                        err_next   = 1'b1;
                    end else if (poll_busy) begin
                        req_valid = 1'b1;
                        req_addr  = ADDR_STATUS;
                    end
                end

                ST_RESULT_RD: begin
                    if (rdata_valid) begin
                        result_valid_next = 1'b1;
                        result_data_next  = rdata;
                        state_next        = ST_READY;
                    end
                end

                ST_ERR: begin
                    // Terminal until reset
                end

                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    assign sample_ready = (state_reg == ST_READY);
    assign busy         = !(state_reg == ST_IDLE || state_reg == ST_READY || state_reg == ST_ERR);
    assign err          = err_reg;
    assign result_valid = result_valid_reg;
    assign result_data  = result_data_reg;
    assign hsize        = 1'b1;

endmodule

// File: tb/tb_ahb_lite_fir_master.sv
// -----------------------------------------------------------------------------
// tb_ahb_lite_fir_master
// Directed bench for ahb_lite_fir_master with a zero-wait-state FIR slave
// model. Honours POLL_TIMEOUT_EN (adds the poll timeout scenario).
// -----------------------------------------------------------------------------
module tb_ahb_lite_fir_master;

`ifdef POLL_TIMEOUT_EN
    localparam int TB_POLL_LIMIT = 4;
    localparam int EXTRA_POLLS   = 2;
`else
    localparam int TB_POLL_LIMIT = 64;
    localparam int EXTRA_POLLS   = 5;
`endif

    logic        clk;
    logic        rst;
    logic        coef_load;
    logic [63:0] coef_in;
    logic        sample_valid;
    logic [15:0] sample_data;
    logic        sample_ready;
    logic        result_valid;
    logic [15:0] result_data;
    logic        busy;
    logic        err;
    logic        hsel;
    logic [1:0]  htrans;
    logic [3:0]  haddr;
    logic        hsize;
    logic        hwrite;
    logic [15:0] hwdata;
    logic [15:0] hrdata;
    logic        hresp;

    int n_checks = 0;
    int n_errors = 0;

    ahb_lite_fir_master #(
        .POLL_LIMIT (TB_POLL_LIMIT),
        .DATA_W     (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .coef_load    (coef_load),
        .coef_in      (coef_in),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .sample_ready (sample_ready),
        .result_valid (result_valid),
        .result_data  (result_data),
        .busy         (busy),
        .err          (err),
        .hsel         (hsel),
        .htrans       (htrans),
        .haddr        (haddr),
        .hsize        (hsize),
        .hwrite       (hwrite),
        .hwdata       (hwdata),
        .hrdata       (hrdata),
        .hresp        (hresp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Slave model (zero wait states) and bus monitors
    // ------------------------------------------------------------------
    int          cyc = 0;
    logic        s_valid = 1'b0;
    logic        s_write = 1'b0;
    logic [3:0]  s_addr = '0;
    int          rd_cnt [16];
    int          rv_pulses = 0;
    int          trans_cnt = 0;
    logic [3:0]  wl_addr [$];
    logic [15:0] wl_data [$];
    int          wl_cyc  [$];

    // Stimulus-owned slave configuration
    int          st_base = 0;
    int          st_busy_n = 0;
    int          cs_base = 0;
    int          cs_busy_n = 0;
    logic [15:0] res_val = '0;
    logic        fault_en = 1'b0;
    logic [3:0]  fault_addr = '0;

    initial begin
        for (int i = 0; i < 16; i++) rd_cnt[i] = 0;
    end

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        s_valid <= (htrans == 2'b10);
        s_write <= hwrite;
        s_addr  <= haddr;
        if (htrans == 2'b10) trans_cnt <= trans_cnt + 1;
        if (result_valid) rv_pulses <= rv_pulses + 1;
        if (s_valid && s_write) begin
            wl_addr.push_back(s_addr);
            wl_data.push_back(hwdata);
            wl_cyc.push_back(cyc);
            $display("bus  wr addr=%0d data=%h cyc=%0d", s_addr, hwdata, cyc);
        end
        if (s_valid && !s_write) rd_cnt[s_addr] <= rd_cnt[s_addr] + 1;
    end

    always_comb begin
        hrdata = '0;
        hresp  = 1'b0;
        if (s_valid && !s_write) begin
            case (s_addr)
                4'd0:  hrdata[0] = ((rd_cnt[0] - st_base) < st_busy_n);
                4'd2:  hrdata    = res_val;
                4'd14: hrdata[0] = ((rd_cnt[14] - cs_base) < cs_busy_n);
                default: hrdata  = '0;
            endcase
        end
        if (s_valid && fault_en && s_addr == fault_addr) hresp = 1'b1;
    end

    // ------------------------------------------------------------------
    // Checker
    // ------------------------------------------------------------------
    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic load_coefs(input logic [63:0] coefs, input int set_busy);
        int w0;
        int r14;
        int gaps;
        int n;
        cs_base   = rd_cnt[14];
        cs_busy_n = set_busy;
        w0        = wl_addr.size();
        r14       = rd_cnt[14];
        gaps      = 0;
        @(negedge clk);
        coef_load = 1'b1;
        coef_in   = coefs;
        @(negedge clk);
        coef_load = 1'b0;
        coef_in   = '0;
        n = 0;
        while (!sample_ready && n < 200) begin
            if (!busy) gaps++;
            @(negedge clk);
            n++;
        end
        chk_eq("coef_ready", sample_ready, 1);
        chk_eq("coef_busy_gaps", gaps, 0);
        chk_eq("coef_wr_count", wl_addr.size() - w0, 5);
        if (wl_addr.size() - w0 >= 5) begin
            for (int i = 0; i < 4; i++) begin
                chk_eq($sformatf("coef%0d_addr", i), wl_addr[w0+i], 6 + 2*i);
                chk_eq($sformatf("coef%0d_data", i), wl_data[w0+i], coefs[i*16 +: 16]);
                chk_eq($sformatf("coef%0d_cycle", i), wl_cyc[w0+i+1] - wl_cyc[w0+i], 1);
            end
            chk_eq("coefset_addr", wl_addr[w0+4], 14);
            chk_eq("coefset_data", wl_data[w0+4], 16'h0001);
        end
        chk_eq("coefset_polls", rd_cnt[14] - r14, set_busy + 1);
    endtask

    task automatic run_sample(input logic [15:0] data, input int busy_n,
                              input logic [15:0] res, input int exp_lat);
        int c0;
        int r0;
        int r2;
        int p0;
        int w0;
        int n;
        st_base   = rd_cnt[0];
        st_busy_n = busy_n;
        res_val   = res;
        r0 = rd_cnt[0];
        r2 = rd_cnt[2];
        p0 = rv_pulses;
        w0 = wl_addr.size();
        @(negedge clk);
        chk_eq("smp_ready", sample_ready, 1);
        sample_valid = 1'b1;
        sample_data  = data;
        c0 = cyc;
        @(negedge clk);
        sample_valid = 1'b0;
        sample_data  = ~data;
        n = 0;
        while (!result_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk_eq("res_valid", result_valid, 1);
        chk_eq("res_latency", cyc - c0, exp_lat);
        chk_eq("res_data", result_data, res);
        @(negedge clk);
        chk_eq("res_pulse_end", result_valid, 0);
        repeat (3) @(negedge clk);
        chk_eq("res_pulses", rv_pulses - p0, 1);
        chk_eq("stat_reads", rd_cnt[0] - r0, busy_n + 1);
        chk_eq("result_reads", rd_cnt[2] - r2, 1);
        chk_eq("smp_wr_count", wl_addr.size() - w0, 1);
        if (wl_addr.size() > w0) begin
            chk_eq("smp_wr_addr", wl_addr[w0], 4);
            chk_eq("smp_wr_data", wl_data[w0], data);
        end
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        int p0;
        int t0;
        int n;
        rst          = 1'b1;
        coef_load    = 1'b0;
        coef_in      = '0;
        sample_valid = 1'b0;
        sample_data  = '0;
        repeat (3) @(negedge clk);

        // Reset values
        chk_eq("rst_htrans", htrans, 0);
        chk_eq("rst_hsel", hsel, 0);
        chk_eq("rst_haddr", haddr, 0);
        chk_eq("rst_hwrite", hwrite, 0);
        chk_eq("rst_hwdata", hwdata, 0);
        chk_eq("rst_hsize", hsize, 1);
        chk_eq("rst_busy", busy, 0);
        chk_eq("rst_err", err, 0);
        chk_eq("rst_ready", sample_ready, 0);
        chk_eq("rst_rvalid", result_valid, 0);
        chk_eq("rst_rdata", result_data, 0);
        rst = 1'b0;

        // Sample offered before any coefficient load is not accepted
        sample_valid = 1'b1;
        sample_data  = 16'h5555;
        repeat (4) @(negedge clk);
        chk_eq("preload_ready", sample_ready, 0);
        chk_eq("preload_htrans", htrans, 0);
        sample_valid = 1'b0;

        // Coefficient load, slave reports set-busy twice
        load_coefs(64'h2118_1571_1321_1111, 2);

        // Samples: no extra polls, one extra poll, several extra polls
        run_sample(16'h6070, 0, 16'hBEEF, 6);
        run_sample(16'h0042, 1, 16'h1234, 8);
        run_sample(16'hA5A5, EXTRA_POLLS, 16'h0F0F, 6 + 2*EXTRA_POLLS);

        // Reset while polling status
        st_base   = rd_cnt[0];
        st_busy_n = 50;
        @(negedge clk);
        sample_valid = 1'b1;
        sample_data  = 16'h7777;
        @(negedge clk);
        sample_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk_eq("mid_busy", busy, 1);
        p0  = rv_pulses;
        rst = 1'b1;
        @(negedge clk);
        chk_eq("midrst_htrans", htrans, 0);
        chk_eq("midrst_hsel", hsel, 0);
        chk_eq("midrst_haddr", haddr, 0);
        chk_eq("midrst_hwdata", hwdata, 0);
        chk_eq("midrst_busy", busy, 0);
        chk_eq("midrst_rvalid", result_valid, 0);
        rst       = 1'b0;
        st_busy_n = 0;
        repeat (20) @(negedge clk);
        chk_eq("midrst_no_result", rv_pulses - p0, 0);
        chk_eq("midrst_idle_ready", sample_ready, 0);

        // Bus error on the coefficient write to address 8
        fault_addr = 4'd8;
        fault_en   = 1'b1;
        @(negedge clk);
        coef_load = 1'b1;
        coef_in   = 64'h4444_3333_2222_1111;
        @(negedge clk);
        coef_load = 1'b0;
        n = 0;
        while (!hresp && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk_eq("fault_seen", hresp, 1);
        @(negedge clk);
        fault_en = 1'b0;
        chk_eq("fault_htrans", htrans, 0);
        chk_eq("fault_err", err, 1);
        t0 = trans_cnt;
        sample_valid = 1'b1;
        coef_load    = 1'b1;
        @(negedge clk);
        coef_load = 1'b0;
        repeat (8) @(negedge clk);
        chk_eq("err_no_trans", trans_cnt - t0, 0);
        chk_eq("err_ready", sample_ready, 0);
        chk_eq("err_sticky", err, 1);
        chk_eq("err_busy", busy, 0);
        sample_valid = 1'b0;
        pulse_reset();
        chk_eq("err_cleared", err, 0);

`ifdef POLL_TIMEOUT_EN
        // Status stuck busy: POLL_LIMIT reads, then error
        load_coefs(64'h0004_0003_0002_0001, 0);
        st_base   = rd_cnt[0];
        st_busy_n = 1000;
        t0        = rd_cnt[0];
        @(negedge clk);
        sample_valid = 1'b1;
        sample_data  = 16'h0101;
        @(negedge clk);
        sample_valid = 1'b0;
        n = 0;
        while (!err && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk_eq("tmo_err", err, 1);
        repeat (3) @(negedge clk);
        chk_eq("tmo_reads", rd_cnt[0] - t0, TB_POLL_LIMIT);
        chk_eq("tmo_busy", busy, 0);
        chk_eq("tmo_ready", sample_ready, 0);
        st_busy_n = 0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
